// File: rtl/writeback_ctrl.sv
// Writeback sequencer: latches the writeback mux select and destination class,
// waits on memory or mul/div completion, then issues one RegWrite pulse or an error pulse.
module writeback_ctrl #(
  parameter int MEM_WAIT   = 1,
  parameter int MD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_req,
  input  logic [3:0] wb_src,
  input  logic [1:0] wb_dst,
  input  logic       md_done,
  output logic [3:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       wb_busy,
  output logic       wb_done,
  output logic       wb_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEMWAIT, S_MDWAIT, S_WRITE, S_ERR
  } state_e;

  localparam bit       HAS_MEM_WAIT = (MEM_WAIT > 0);
  localparam logic [7:0] MEM_LOAD   = 8'(HAS_MEM_WAIT ? MEM_WAIT - 1 : 0);
  localparam logic [7:0] MD_LAST    = 8'(MD_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] mtr_q, mtr_d;
  logic [1:0] rdst_q, rdst_d;

  logic src_mem, src_md, src_bad;
  assign src_mem = (wb_src == 4'd2) || (wb_src == 4'd7);
  assign src_md  = (wb_src == 4'd4) || (wb_src == 4'd5);
  assign src_bad = (wb_src > 4'd8);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mtr_d   = mtr_q;
    rdst_d  = rdst_q;
    case (state_q)
      S_IDLE: begin
        if (wb_req) begin
          if (src_bad) begin
            // invalid codes leave the mux selects untouched
            state_d = S_ERR;
          end else begin
            mtr_d  = wb_src;
            rdst_d = wb_dst;
            if (src_mem && HAS_MEM_WAIT) begin
              state_d = S_MEMWAIT;
              cnt_d   = MEM_LOAD;
            end else if (src_md && !md_done) begin
              state_d = S_MDWAIT;
              cnt_d   = 8'd0;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_MEMWAIT: begin
        if (cnt_q == 8'd0) state_d = S_WRITE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_MDWAIT: begin
        // md_done takes priority over the timeout on the final wait cycle
        if (md_done)               state_d = S_WRITE;
        else if (cnt_q >= MD_LAST) state_d = S_ERR;
        else                       cnt_d   = cnt_q + 8'd1;
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      mtr_q   <= 4'd0;
      rdst_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mtr_q   <= mtr_d;
      rdst_q  <= rdst_d;
    end
  end

  // pulses decode straight from state so an async reset kills them at once
  assign MemtoReg = mtr_q;
  assign RegDst   = rdst_q;
  assign RegWrite = (state_q == S_WRITE);
  assign wb_done  = (state_q == S_WRITE);
  assign wb_err   = (state_q == S_ERR);
  assign wb_busy  = (state_q != S_IDLE);

endmodule
